// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Purpose  : Shared encodings, state enum and ALU decode for the EX stage.
//  Revision : 1.0
// ============================================================================
package ex_pkg;

    localparam int EX_DATA_W = 64;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    typedef enum logic [2:0] {
        FN_ADD   = 3'd0,
        FN_SUB   = 3'd1,
        FN_AND   = 3'd2,
        FN_ORR   = 3'd3,
        FN_PASSB = 3'd4,
        FN_MUL   = 3'd5,
        FN_ILL   = 3'd6
    } alu_fn_e;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [4:0] write_reg;
    } ex_ctrl_t;

    function automatic alu_fn_e alu_decode(input logic [1:0]  aluop,
                                           input logic [10:0] opcode);
        alu_fn_e fn;
        fn = FN_ILL;
        case (aluop)
            ALUOP_ADD:   fn = FN_ADD;
            ALUOP_PASSB: fn = FN_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: fn = FN_ADD;
                    OPC_SUB: fn = FN_SUB;
                    OPC_AND: fn = FN_AND;
                    OPC_ORR: fn = FN_ORR;
                    OPC_MUL: fn = FN_MUL;
                    default: fn = FN_ILL;
                endcase
            end
            ALUOP_RSVD:  fn = FN_ILL;
            default:     fn = FN_ILL;
        endcase
        return fn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mul_iter
//  Purpose  : Iterative shift-add multiplier, one multiplier bit per edge.
//             Only instantiated when EX_MUL_EN is defined.
//  Revision : 1.0
// ============================================================================
module ex_mul_iter #(
    parameter int DATA_W     = 64,
    parameter int MUL_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MUL_CYCLES - 1);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_sh_q;
    logic [DATA_W-1:0] b_sh_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] w_addend;

    // The final partial sum is exposed combinationally so the stage can
    // register the product on the same edge as the last iteration.
    always_comb begin
        w_addend  = b_sh_q[0] ? a_sh_q : '0;
        acc_d     = acc_q + w_addend;
        done_o    = busy_q & (cnt_q == C_LAST);
        product_o = acc_d;
    end

    always_ff @(negedge clk) begin
        if (reset || abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            a_sh_q <= a_i;
            b_sh_q <= b_i;
            acc_q  <= '0;
        end else if (busy_q) begin
            acc_q  <= acc_d;
            a_sh_q <= a_sh_q << 1;
            b_sh_q <= b_sh_q >> 1;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage with EX/MEM output register, falling-edge timed.
//             Define EX_MUL_EN to build the iterative 64-bit multiplier.
//  Revision : 1.0
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W     = EX_DATA_W,
    parameter int MUL_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtendImmediate,
    input  logic              ALUSrc,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic [1:0]        ALUOp,
    input  logic [4:0]        WriteReg,
    input  logic [10:0]       Opcode,
    input  logic [DATA_W-1:0] PC,
    input  logic              Flush,
    input  logic              MemReady,
    output logic              Stall,
    output logic              ValidOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic              ZeroOut,
    output logic [DATA_W-1:0] BranchTargetOut,
    output logic              BranchTakenOut,
    output logic [DATA_W-1:0] ReadData2Out,
    output logic              MemtoRegOut,
    output logic              RegWriteOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic [4:0]        WriteRegOut,
    output logic              IllegalOut
);

`ifdef EX_MUL_EN
    localparam bit MUL_HW = (MUL_CYCLES == DATA_W);
`else
    localparam bit MUL_HW = 1'b0 && (MUL_CYCLES == DATA_W);
`endif

    ex_state_e         state_q, state_d;
    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic [DATA_W-1:0] target_q;
    logic              taken_q;
    logic [DATA_W-1:0] rd2_q;
    logic              illegal_q;
    ex_ctrl_t          ctrl_q;

    alu_fn_e           w_fn;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_target;
    logic              w_zero;
    logic              w_illegal;
    logic              w_is_mul;
    logic              w_stall;
    logic              w_accept;
    ex_ctrl_t          w_ctrl;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    always_comb begin
        w_b  = ALUSrc ? SignExtendImmediate : ReadData2;
        w_fn = alu_decode(ALUOp, Opcode);
        // Without multiplier hardware the MUL opcode decodes as illegal.
        if (w_fn == FN_MUL && !MUL_HW) begin
            w_fn = FN_ILL;
        end
        w_result = '0;
        case (w_fn)
            FN_ADD:   w_result = ReadData1 + w_b;
            FN_SUB:   w_result = ReadData1 - w_b;
            FN_AND:   w_result = ReadData1 & w_b;
            FN_ORR:   w_result = ReadData1 | w_b;
            FN_PASSB: w_result = w_b;
            default:  w_result = '0;
        endcase
        w_zero    = (w_result == '0);
        w_illegal = (w_fn == FN_ILL);
        w_is_mul  = (w_fn == FN_MUL);
        w_target  = PC + (SignExtendImmediate << 2);

        w_ctrl.mem_to_reg = MemtoReg;
        w_ctrl.reg_write  = RegWrite & ~w_illegal;
        w_ctrl.mem_read   = MemRead;
        w_ctrl.mem_write  = MemWrite & ~w_illegal;
        w_ctrl.branch     = Branch;
        w_ctrl.write_reg  = WriteReg;
    end

    assign w_stall  = (state_q == ST_MUL) | (valid_q & ~MemReady);
    assign w_accept = hit & ~w_stall & ~Flush;

`ifdef EX_MUL_EN
    logic w_mul_start;
    assign w_mul_start = w_accept & w_is_mul;

    ex_mul_iter #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .abort_i   (Flush),
        .start_i   (w_mul_start),
        .a_i       (ReadData1),
        .b_i       (w_b),
        .done_o    (w_mul_done),
        .product_o (w_mul_product)
    );
`else
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept && w_is_mul) state_d = ST_MUL;
            ST_MUL:  if (w_mul_done)           state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (Flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A MUL accept latches everything except the result; the result and
    // ValidOut land on the final iteration edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            target_q  <= '0;
            taken_q   <= 1'b0;
            rd2_q     <= '0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else if (Flush) begin
            valid_q   <= 1'b0;
        end else if (w_accept) begin
            ctrl_q    <= w_ctrl;
            target_q  <= w_target;
            rd2_q     <= ReadData2;
            illegal_q <= w_illegal;
            if (w_is_mul) begin
                valid_q  <= 1'b0;
            end else begin
                valid_q  <= 1'b1;
                result_q <= w_result;
                zero_q   <= w_zero;
                taken_q  <= Branch & w_zero;
            end
        end else if (w_mul_done) begin
            valid_q   <= 1'b1;
            result_q  <= w_mul_product;
            zero_q    <= (w_mul_product == '0);
            taken_q   <= ctrl_q.branch & (w_mul_product == '0);
        end else if (valid_q && MemReady) begin
            valid_q   <= 1'b0;
        end
    end

    assign Stall           = w_stall;
    assign ValidOut        = valid_q;
    assign ALUResultOut    = result_q;
    assign ZeroOut         = zero_q;
    assign BranchTargetOut = target_q;
    assign BranchTakenOut  = taken_q;
    assign ReadData2Out    = rd2_q;
    assign MemtoRegOut     = ctrl_q.mem_to_reg;
    assign RegWriteOut     = ctrl_q.reg_write;
    assign MemReadOut      = ctrl_q.mem_read;
    assign MemWriteOut     = ctrl_q.mem_write;
    assign WriteRegOut     = ctrl_q.write_reg;
    assign IllegalOut      = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Self-checking bench for ex_stage: vector table, hand sequences
//             and randomized traffic against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_ex_stage;

    localparam logic [10:0] T_ADD = 11'b10001011000;
    localparam logic [10:0] T_SUB = 11'b11001011000;
    localparam logic [10:0] T_AND = 11'b10001010000;
    localparam logic [10:0] T_ORR = 11'b10101010000;
    localparam logic [10:0] T_MUL = 11'b10011011000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [1:0]  aluop;
        logic [10:0] opc;
        logic        alusrc;
        logic [63:0] a, rd2, imm, pc;
        logic        branch, memread, memwrite, regwrite, memtoreg;
        logic [4:0]  wreg;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic [63:0] res;
        logic        zero;
        logic [63:0] target;
        logic        taken;
        logic        ill;
        logic        rw;
    } vec_t;

    logic clk = 1'b0;
    logic reset, hit, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic Flush, MemReady;
    logic [63:0] ReadData1, ReadData2, SignExtendImmediate, PC;
    logic [1:0]  ALUOp;
    logic [4:0]  WriteReg;
    logic [10:0] Opcode;
    logic        Stall, ValidOut, ZeroOut, BranchTakenOut, MemtoRegOut;
    logic        RegWriteOut, MemReadOut, MemWriteOut, IllegalOut;
    logic [63:0] ALUResultOut, BranchTargetOut, ReadData2Out;
    logic [4:0]  WriteRegOut;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .hit(hit),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .SignExtendImmediate(SignExtendImmediate),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .ALUOp(ALUOp), .WriteReg(WriteReg), .Opcode(Opcode), .PC(PC),
        .Flush(Flush), .MemReady(MemReady),
        .Stall(Stall), .ValidOut(ValidOut), .ALUResultOut(ALUResultOut),
        .ZeroOut(ZeroOut), .BranchTargetOut(BranchTargetOut),
        .BranchTakenOut(BranchTakenOut), .ReadData2Out(ReadData2Out),
        .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut),
        .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .WriteRegOut(WriteRegOut), .IllegalOut(IllegalOut)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // DUT state changes on the falling edge; the bench drives and samples
    // on the rising edge, half a period away.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic instr_t mk(input logic [1:0] aluop, input logic [10:0] opc,
                                  input logic alusrc, input logic [63:0] a, rd2, imm, pc,
                                  input logic branch, memread, memwrite, regwrite, memtoreg,
                                  input logic [4:0] wreg);
        instr_t i;
        i.aluop = aluop; i.opc = opc; i.alusrc = alusrc;
        i.a = a; i.rd2 = rd2; i.imm = imm; i.pc = pc;
        i.branch = branch; i.memread = memread; i.memwrite = memwrite;
        i.regwrite = regwrite; i.memtoreg = memtoreg; i.wreg = wreg;
        return i;
    endfunction

    function automatic void addv(input instr_t i, input logic [63:0] res, input logic zero,
                                 input logic [63:0] target, input logic taken,
                                 input logic ill, input logic rw);
        vec_t v;
        v.in = i; v.res = res; v.zero = zero; v.target = target;
        v.taken = taken; v.ill = ill; v.rw = rw;
        vq.push_back(v);
    endfunction

    task automatic apply(input instr_t i, input logic h);
        hit = h;
        ALUOp = i.aluop; Opcode = i.opc; ALUSrc = i.alusrc;
        ReadData1 = i.a; ReadData2 = i.rd2; SignExtendImmediate = i.imm; PC = i.pc;
        Branch = i.branch; MemRead = i.memread; MemWrite = i.memwrite;
        RegWrite = i.regwrite; MemtoReg = i.memtoreg; WriteReg = i.wreg;
    endtask

    // Reference ALU: returns {illegal, result}.
    function automatic logic [64:0] ref_alu(input instr_t i);
        logic [63:0] b;
        b = i.alusrc ? i.imm : i.rd2;
        if (i.aluop == 2'b00) return {1'b0, i.a + b};
        if (i.aluop == 2'b01) return {1'b0, b};
        if (i.aluop == 2'b10) begin
            if (i.opc == T_ADD) return {1'b0, i.a + b};
            if (i.opc == T_SUB) return {1'b0, i.a - b};
            if (i.opc == T_AND) return {1'b0, i.a & b};
            if (i.opc == T_ORR) return {1'b0, i.a | b};
        end
        return {1'b1, 64'd0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t ir;
        int     n;
        logic        m_valid, e_ill, e_rw, e_mw, e_zero, e_taken, e_stall;
        logic [63:0] e_res, e_tgt;
        logic [4:0]  e_wreg;
        logic [64:0] r;

        apply(mk(2'b00, 11'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0), 1'b0);
        reset = 1'b1; Flush = 1'b0; MemReady = 1'b1;
        step(); step();
        chk("reset_valid",  ValidOut, 0);
        chk("reset_result", ALUResultOut, 0);
        chk("reset_target", BranchTargetOut, 0);
        chk("reset_stall",  Stall, 0);
        chk("reset_illegal", IllegalOut, 0);
        reset = 1'b0;

        // ---------------- table-driven single-cycle vectors ----------------
        addv(mk(2'b10, T_ADD, 0, 5, 7, 0, 0, 0, 0, 0, 1, 0, 5'd1), 12, 0, 0, 0, 0, 1);
        addv(mk(2'b10, T_SUB, 0, 64'h1234, 64'h1234, 0, 64'h40, 0, 0, 0, 1, 0, 5'd2), 0, 1, 64'h40, 0, 0, 1);
        addv(mk(2'b00, 11'd0, 1, 64'h100, 64'hDEAD, 8, 64'h200, 0, 1, 0, 1, 1, 5'd3), 64'h108, 0, 64'h220, 0, 0, 1);
        addv(mk(2'b01, 11'd0, 0, 64'h55, 0, 4, 64'h100, 1, 0, 0, 0, 0, 5'd0), 0, 1, 64'h110, 1, 0, 0);
        addv(mk(2'b01, 11'd0, 0, 64'h55, 3, 4, 64'h100, 1, 0, 0, 0, 0, 5'd0), 3, 0, 64'h110, 0, 0, 0);
        addv(mk(2'b10, T_AND, 0, 64'hF0F0, 64'h0FF0, 0, 0, 0, 0, 0, 1, 0, 5'd4), 64'hF0, 0, 0, 0, 0, 1);
        addv(mk(2'b10, T_ORR, 0, 64'hF000, 64'h000F, 0, 0, 0, 0, 0, 1, 0, 5'd5), 64'hF00F, 0, 0, 0, 0, 1);
        addv(mk(2'b10, T_SUB, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 5'd6), ONES, 0, 0, 0, 0, 1);
        addv(mk(2'b00, 11'd0, 1, ONES, 0, 1, 64'h1000, 0, 0, 0, 1, 0, 5'd7), 0, 1, 64'h1004, 0, 0, 1);
        addv(mk(2'b11, T_ADD, 0, 5, 7, ONES, 64'h100, 0, 0, 1, 1, 0, 5'd8), 0, 1, 64'hFC, 0, 1, 0);
        addv(mk(2'b10, 11'h7FF, 0, 5, 7, 0, 0, 0, 0, 1, 1, 0, 5'd9), 0, 1, 0, 0, 1, 0);
        addv(mk(2'b10, T_ORR, 1, 1, 64'hFFFF, 64'h10, 0, 0, 0, 1, 0, 0, 5'd10), 64'h11, 0, 64'h40, 0, 0, 0);

        foreach (vq[k]) begin
            apply(vq[k].in, 1'b1);
            step();
            chk($sformatf("vec%0d_valid", k),  ValidOut, 1);
            chk($sformatf("vec%0d_result", k), ALUResultOut, vq[k].res);
            chk($sformatf("vec%0d_zero", k),   ZeroOut, vq[k].zero);
            chk($sformatf("vec%0d_target", k), BranchTargetOut, vq[k].target);
            chk($sformatf("vec%0d_taken", k),  BranchTakenOut, vq[k].taken);
            chk($sformatf("vec%0d_illegal", k), IllegalOut, vq[k].ill);
            chk($sformatf("vec%0d_regwrite", k), RegWriteOut, vq[k].rw);
            chk($sformatf("vec%0d_memwrite", k), MemWriteOut, vq[k].in.memwrite & ~vq[k].ill);
            chk($sformatf("vec%0d_memread", k), MemReadOut, vq[k].in.memread);
            chk($sformatf("vec%0d_wreg", k),   WriteRegOut, vq[k].in.wreg);
            chk($sformatf("vec%0d_rd2", k),    ReadData2Out, vq[k].in.rd2);
        end
        hit = 1'b0;
        step();
        chk("consume_valid", ValidOut, 0);

        // ---------------- backpressure ----------------
        apply(mk(2'b10, T_ADD, 0, 5, 7, 0, 0, 0, 0, 0, 1, 0, 5'd1), 1'b1);
        step();
        chk("bp_first", ALUResultOut, 12);
        apply(mk(2'b10, T_SUB, 0, 10, 3, 0, 0, 0, 0, 0, 1, 0, 5'd2), 1'b1);
        MemReady = 1'b0;
        #1;
        chk("bp_stall", Stall, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_hold_result", ALUResultOut, 12);
            chk("bp_hold_valid",  ValidOut, 1);
            chk("bp_hold_stall",  Stall, 1);
        end
        MemReady = 1'b1;
        #1;
        chk("bp_release_stall", Stall, 0);
        step();
        chk("bp_replace_result", ALUResultOut, 7);
        chk("bp_replace_valid",  ValidOut, 1);
        hit = 1'b0;
        step();

        // ---------------- multiply ----------------
`ifdef EX_MUL_EN
        apply(mk(2'b10, T_MUL, 0, 6, 7, 0, 0, 0, 0, 0, 1, 0, 5'd11), 1'b1);
        step();
        hit = 1'b0;
        n = 1;
        while (ValidOut !== 1'b1 && n < 200) begin
            chk("mul_stall", Stall, 1);
            step();
            n++;
        end
        chk("mul_latency", n, 65);
        chk("mul_result", ALUResultOut, 42);
        chk("mul_stall_end", Stall, 0);
        chk("mul_regwrite", RegWriteOut, 1);
        apply(mk(2'b10, T_MUL, 0, ONES, 2, 0, 0, 0, 0, 0, 1, 0, 5'd12), 1'b1);
        step();
        hit = 1'b0;
        n = 1;
        while (ValidOut !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("mul2_latency", n, 65);
        chk("mul2_result", ALUResultOut, 64'hFFFF_FFFF_FFFF_FFFE);
        step();

        // reset during multiply
        apply(mk(2'b10, T_MUL, 0, 6, 7, 0, 64'h80, 0, 0, 0, 1, 0, 5'd11), 1'b1);
        step();
        hit = 1'b0;
        repeat (20) step();
        chk("mid_mul_stall", Stall, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mul_stall",  Stall, 0);
        chk("rst_mul_valid",  ValidOut, 0);
        chk("rst_mul_result", ALUResultOut, 0);
        chk("rst_mul_target", BranchTargetOut, 0);
        chk("rst_mul_rw",     RegWriteOut, 0);

        // flush during multiply
        apply(mk(2'b10, T_MUL, 0, 6, 7, 0, 0, 0, 0, 0, 1, 0, 5'd11), 1'b1);
        step();
        hit = 1'b0;
        repeat (20) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_mul_stall", Stall, 0);
        chk("flush_mul_valid", ValidOut, 0);
        apply(mk(2'b10, T_ADD, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 5'd1), 1'b1);
        step();
        chk("post_flush_result", ALUResultOut, 3);
        chk("post_flush_valid",  ValidOut, 1);
        hit = 1'b0;
        step();
`else
        apply(mk(2'b10, T_MUL, 0, 6, 7, 0, 0, 0, 0, 1, 1, 0, 5'd11), 1'b1);
        step();
        hit = 1'b0;
        chk("mul_ill_valid",   ValidOut, 1);
        chk("mul_ill_illegal", IllegalOut, 1);
        chk("mul_ill_result",  ALUResultOut, 0);
        chk("mul_ill_rw",      RegWriteOut, 0);
        chk("mul_ill_mw",      MemWriteOut, 0);
        chk("mul_ill_stall",   Stall, 0);
        step();

        // reset with a live output instruction
        apply(mk(2'b10, T_ADD, 0, 5, 7, 1, 64'h80, 0, 0, 0, 1, 0, 5'd1), 1'b1);
        step();
        hit = 1'b0;
        chk("pre_rst_valid", ValidOut, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_stall",  Stall, 0);
        chk("rst_valid",  ValidOut, 0);
        chk("rst_result", ALUResultOut, 0);
        chk("rst_target", BranchTargetOut, 0);
        chk("rst_rw",     RegWriteOut, 0);

        // flush beats backpressure
        apply(mk(2'b10, T_ADD, 0, 5, 7, 0, 0, 0, 0, 0, 1, 0, 5'd1), 1'b1);
        step();
        MemReady = 1'b0;
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_valid", ValidOut, 0);
        chk("flush_stall", Stall, 0);
        hit = 1'b0;
        MemReady = 1'b1;
        step();
`endif

        // ---------------- randomized traffic vs. model ----------------
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        m_valid = 1'b0;
        e_res = '0; e_ill = 0; e_rw = 0; e_mw = 0; e_zero = 0; e_taken = 0;
        e_tgt = '0; e_wreg = '0;
        for (int c = 0; c < 300; c++) begin
            ir.aluop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: ir.opc = T_ADD;
                1: ir.opc = T_SUB;
                2: ir.opc = T_AND;
                3: ir.opc = T_ORR;
                default: ir.opc = 11'($urandom);
            endcase
            if (ir.opc == T_MUL) ir.opc = T_ADD;
            ir.alusrc = 1'($urandom);
            ir.a   = {$urandom, $urandom};
            ir.rd2 = ($urandom_range(0, 3) == 0) ? ir.a : {$urandom, $urandom};
            ir.imm = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            if (ir.alusrc && $urandom_range(0, 3) == 0) ir.imm = ir.a;
            ir.pc  = {$urandom, $urandom};
            ir.branch = 1'($urandom); ir.memread = 1'($urandom);
            ir.memwrite = 1'($urandom); ir.regwrite = 1'($urandom);
            ir.memtoreg = 1'($urandom); ir.wreg = 5'($urandom);
            apply(ir, 1'($urandom));
            MemReady = ($urandom_range(0, 9) < 7);
            Flush    = ($urandom_range(0, 19) == 0);
            #1;
            e_stall = m_valid & ~MemReady;
            chk("rnd_stall", Stall, e_stall);
            step();
            if (Flush) begin
                m_valid = 1'b0;
            end else if (hit && !e_stall) begin
                r = ref_alu(ir);
                m_valid = 1'b1;
                e_ill   = r[64];
                e_res   = r[63:0];
                e_zero  = (e_res == 0);
                e_taken = ir.branch & e_zero;
                e_rw    = ir.regwrite & ~e_ill;
                e_mw    = ir.memwrite & ~e_ill;
                e_tgt   = ir.pc + ir.imm * 4;
                e_wreg  = ir.wreg;
            end else if (m_valid && MemReady) begin
                m_valid = 1'b0;
            end
            chk("rnd_valid", ValidOut, m_valid);
            if (m_valid) begin
                chk("rnd_result",  ALUResultOut, e_res);
                chk("rnd_zero",    ZeroOut, e_zero);
                chk("rnd_taken",   BranchTakenOut, e_taken);
                chk("rnd_illegal", IllegalOut, e_ill);
                chk("rnd_rw",      RegWriteOut, e_rw);
                chk("rnd_mw",      MemWriteOut, e_mw);
                chk("rnd_target",  BranchTargetOut, e_tgt);
                chk("rnd_wreg",    WriteRegOut, e_wreg);
            end
        end
        Flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
